// File: rtl/usr_pkg.sv
// Shared definitions for the parallel-to-serial transmit path: shift-register
// mode codes and the serializer controller state encoding.
package usr_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10
    } usr_state_e;

    // MSB-first words leave from the top, so the register shifts left.
    function automatic logic [1:0] shift_code(input logic msb_first);
        return msb_first ? USR_SHL : USR_SHR;
    endfunction

endpackage

// File: rtl/usr_serializer_ctrl_if.sv
// Upstream word handshake and downstream serial-bit handshake of the
// serializer controller.
interface usr_serializer_ctrl_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_msb_first;
    logic         in_fill;
    logic         ser_valid;
    logic         ser_data;
    logic         ser_ready;
    logic         frame_done;

    modport master (
        output in_valid, in_data, in_msb_first, in_fill, ser_ready,
        input  in_ready, ser_valid, ser_data, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_msb_first, in_fill, ser_ready,
        output in_ready, ser_valid, ser_data, frame_done
    );
endinterface

// File: rtl/Universal_Shift_register.sv
// N-bit universal shift register (hold / shift right / shift left / load),
// updating on the falling clock edge.
module Universal_Shift_register
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   s,
    input  logic [N-1:0] I,
    input  logic         MSB_in,
    input  logic         LSB_in,
    output logic [N-1:0] Q
);

    // Register contents, updated mid-cycle so the controller sees them at the next rising edge
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else begin
            case (s)
                USR_HOLD: Q <= Q;
                USR_SHR:  Q <= {MSB_in, Q[N-1:1]};
                USR_SHL:  Q <= {Q[N-2:0], LSB_in};
                USR_LOAD: Q <= I;
                default:  Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/usr_serializer_ctrl.sv
// Serializer controller: loads accepted words into the universal shift
// register and streams its boundary bit out one bit per accepted cycle.
module usr_serializer_ctrl
    import usr_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    usr_serializer_ctrl_if.slave bus,
    output logic [1:0]           usr_s,
    output logic [N-1:0]         usr_I,
    output logic                 usr_MSB_in,
    output logic                 usr_LSB_in,
    input  logic [N-1:0]         usr_Q
);

    usr_state_e       state_r;
    usr_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] tap_idx_s;
    logic             msb_first_r;
    logic             ser_valid_r;
    logic             ser_data_r;
    logic             in_ready_s;
    logic             frame_done_s;
    logic             accept_s;
    logic             advance_s;
    logic             last_s;
    logic             boundary_s;

    assign last_s     = (cnt_r == CNT_W'(N - 1));
    assign tap_idx_s  = msb_first_r ? CNT_W'(N - 1) : {CNT_W{1'b0}};
    assign boundary_s = usr_Q[tap_idx_s];

    assign bus.in_ready   = in_ready_s;
    assign bus.frame_done = frame_done_s;
    assign bus.ser_valid  = ser_valid_r;
    assign bus.ser_data   = ser_data_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and combinational mode/handshake outputs; usr_s follows ser_ready within the half cycle
    always_comb begin
        state_s      = state_r;
        usr_s        = USR_HOLD;
        in_ready_s   = 1'b0;
        frame_done_s = 1'b0;
        accept_s     = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                accept_s   = bus.in_valid;
                if (bus.in_valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                usr_s   = USR_LOAD;
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.ser_ready) begin
                    usr_s = shift_code(msb_first_r);
                end else begin
                    usr_s = USR_HOLD;
                end
                frame_done_s = last_s && ser_valid_r;
                advance_s    = ser_valid_r && bus.ser_ready;
                if (advance_s && last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Word capture on acceptance, serial output register and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            usr_I       <= '0;
            usr_MSB_in  <= 1'b0;
            usr_LSB_in  <= 1'b0;
            msb_first_r <= 1'b0;
            ser_valid_r <= 1'b0;
            ser_data_r  <= 1'b0;
            cnt_r       <= '0;
        end else begin
            if (accept_s) begin
                usr_I       <= bus.in_data;
                msb_first_r <= bus.in_msb_first;
                usr_MSB_in  <= bus.in_fill;
                usr_LSB_in  <= bus.in_fill;
            end
            if (state_r == ST_LOAD) begin
                ser_data_r  <= boundary_s;
                ser_valid_r <= 1'b1;
                cnt_r       <= '0;
            end else if (advance_s) begin
                if (last_s) begin
                    ser_valid_r <= 1'b0;
                end else begin
                    cnt_r      <= cnt_r + CNT_W'(1);
                    ser_data_r <= boundary_s;
                end
            end
        end
    end

endmodule
